// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Pulls bytes from a show-ahead FIFO and serializes each one as an 8N1-style
//   UART frame: start bit (0), DATA_WIDTH data bits LSB first, optional even
//   parity bit, stop bit (1). Consecutive frames are sent back to back with no
//   idle gap while tx_en is high and the FIFO has data.
//
//   Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
//   bit between the last data bit and the stop bit.
//
// Parameters
//   DATA_WIDTH    bits per frame (word width of the FIFO)
//   CLKS_PER_BIT  clock cycles per serial bit, must be >= 2
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous reset, active low
//   tx_en       permits a new frame to start (never aborts one in flight)
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO head word, valid while fifo_empty is low
//   fifo_rd     FIFO pop strobe, one registered cycle per consumed word
//   tx          serial output, idle high, registered
//   busy        high while a frame is in progress
//   tx_done     one-cycle pulse in the first cycle after a stop bit ends
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        baud_q,  baud_d;
  logic [BIT_W-1:0]        bit_q,   bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q,    tx_d;
  logic                    fifo_rd_q, fifo_rd_d;
  logic                    tx_done_q, tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic bit_end;
  logic pop_ok;
  logic start_frame;

  assign bit_end = (baud_q == BAUD_LAST);
  assign pop_ok  = tx_en && !fifo_empty;

  // tx is computed one cycle ahead from the next state so the line itself
  // comes straight out of a flop and changes on the same edge as the state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    baud_d      = bit_end ? '0 : baud_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    fifo_rd_d   = 1'b0;
    tx_done_d   = 1'b0;
    start_frame = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop_ok) start_frame = 1'b1;
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          tx_done_d = 1'b1;
          if (pop_ok) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start is shared by IDLE and the back-to-back path out of STOP:
    // capture the head word and pop it in the following cycle.
    if (start_frame) begin
      state_d   = S_START;
      baud_d    = '0;
      shift_d   = fifo_rdata;
      fifo_rd_d = 1'b1;
      tx_d      = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d  = ^fifo_rdata;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      tx_done_q <= tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = fifo_rd_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4).
//   A queue-based show-ahead FIFO model feeds the DUT; every word pushed is also
//   the expected next frame. A monitor decodes the tx line cycle by cycle,
//   builds the expected waveform of each frame from the word's value and
//   compares bit by bit, together with fifo_rd, busy and tx_done framing.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif
  localparam int FRAME = NB * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          tx;
  logic          busy;
  logic          tx_done;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Every word ever pushed, in order. The FIFO model reads it at rd_idx,
  // the monitor consumes expected frames at mon_idx.
  logic [DW-1:0] sent_q[$];
  int            rd_idx  = 0;
  int            mon_idx = 0;
  int            pop_cnt = 0;
  int            pop_cyc[$];
  bit            rand_mode  = 1'b1;
  bit            mon_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    sent_q.push_back(b);
  endtask

  // FIFO model: show-ahead head word, popped in the cycle fifo_rd is high.
  initial begin
    bit prev_rd = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && fifo_rd === 1'b1) begin
        check("fifo_rd consecutive", 32'(prev_rd), 0);
        check("fifo_rd while empty", 32'(rd_idx < sent_q.size()), 1);
        if (rd_idx < sent_q.size()) rd_idx++;
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      prev_rd = fifo_rd;
      if (rand_mode) begin
        fifo_empty = 1'($urandom_range(0, 1));
        fifo_rdata = DW'($urandom);
      end else begin
        fifo_empty = (rd_idx >= sent_q.size());
        fifo_rdata = (rd_idx < sent_q.size()) ? sent_q[rd_idx] : DW'($urandom);
      end
    end
  end

  // Monitor: decodes tx and compares against the expected frame of each word.
  initial begin
    bit            in_frame = 1'b0;
    bit            post     = 1'b0;
    bit            ctl_ok;
    int            fc = 0;
    logic [NB-1:0] bits;
    logic [CPB-1:0] samp;
    logic [CPB-1:0] want;
    logic [DW-1:0] cur;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        in_frame   = 1'b0;
        post       = 1'b0;
        mon_active = 1'b0;
        continue;
      end
      if (in_frame) begin
        samp = {samp[CPB-2:0], tx};
        if (busy !== 1'b1 || tx_done !== 1'b0 || fifo_rd !== 1'b0) ctl_ok = 1'b0;
        if (fc % CPB == CPB - 1) begin
          want = bits[fc / CPB] ? '1 : '0;
          check($sformatf("word %02h bit %0d", cur, fc / CPB), 32'(samp), 32'(want));
        end
        fc++;
        if (fc == FRAME) begin
          check($sformatf("word %02h busy/rd/done in frame", cur), 32'(ctl_ok), 1);
          in_frame = 1'b0;
          post     = 1'b1;
        end
        mon_active = 1'b1;
        continue;
      end
      if (post) check("tx_done after stop", 32'(tx_done), 1);
      else      check("tx_done idle", 32'(tx_done), 0);
      post = 1'b0;
      if (tx === 1'b0) begin
        check("fifo_rd at start bit", 32'(fifo_rd), 1);
        check("busy at start bit", 32'(busy), 1);
        if (mon_idx < sent_q.size()) begin
          cur = sent_q[mon_idx];
          mon_idx++;
        end else begin
          check("unexpected frame", 0, 1);
          cur = '0;
        end
        bits       = '0;
        bits[0]    = 1'b0;
        for (int i = 0; i < DW; i++) bits[1 + i] = cur[i];
`ifdef FIFO_UART_TX_PARITY_EN
        bits[DW+1] = ^cur;
`endif
        bits[NB-1] = 1'b1;
        samp       = '0;
        samp[0]    = tx;
        ctl_ok     = 1'b1;
        fc         = 1;
        in_frame   = 1'b1;
      end else begin
        check("busy idle", 32'(busy), 0);
      end
      mon_active = in_frame || post;
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!(mon_idx == sent_q.size() && !mon_active) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle timeout", 32'(n < max_cyc), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pop(input int p, input int max_cyc);
    int n = 0;
    while (pop_cnt <= p && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_pop timeout", 32'(n < max_cyc), 1);
  endtask

  initial begin
    int p0;
    int lows;
    int n;
    reset = 1'b0;
    tx_en = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_en = 1'($urandom_range(0, 1));
      #1;
      check("reset outputs", 32'({tx, fifo_rd, busy, tx_done}), 32'b1000);
    end
    rand_mode = 1'b0;
    tx_en     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single word.
    p0 = pop_cnt;
    push(8'hA5);
    tx_en = 1'b1;
    wait_idle(200);
    check("A5 pop count", 32'(pop_cnt - p0), 1);

    // Back-to-back pair.
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    wait_idle(300);
    check("pair pop count", 32'(pop_cnt - p0), 2);
    if (pop_cnt - p0 == 2)
      check("pair pop spacing", 32'(pop_cyc[p0+1] - pop_cyc[p0]), 32'(FRAME));

    // Parity pattern (plain frame when parity is not built in).
    push(8'h07);
    wait_idle(200);

    // tx_en low blocks the start.
    tx_en = 1'b0;
    p0    = pop_cnt;
    push(8'h3C);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("tx_en low: tx low cycles", 32'(lows), 0);
    check("tx_en low: pops", 32'(pop_cnt - p0), 0);

    // Drop tx_en during data bit 2: frame completes, next word stays queued.
    push(8'hC3);
    tx_en = 1'b1;
    wait_pop(p0, 20);
    repeat (12) @(negedge clk);
    tx_en = 1'b0;
    n = 0;
    while (!(mon_idx == sent_q.size() - 1 && !mon_active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_en drop: frame timeout", 32'(n < 200), 1);
    repeat (60) @(negedge clk);
    check("tx_en drop: pops", 32'(pop_cnt - p0), 1);
    check("tx_en drop: tx idle", 32'(tx), 1);
    tx_en = 1'b1;
    wait_idle(200);

    // Reset during data bit 3: first word lost, second sent as a full frame.
    p0 = pop_cnt;
    push(8'h5A);
    push(8'h96);
    wait_pop(p0, 20);
    repeat (18) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("mid-frame reset outputs", 32'({tx, fifo_rd, busy, tx_done}), 32'b1000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_idle(300);
    check("reset: pops", 32'(pop_cnt - p0), 2);

    // Random traffic with random tx_en gaps.
    for (int i = 0; i < 24; i++) begin
      push(DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tx_en = 1'b0;
        repeat ($urandom_range(1, 50)) @(negedge clk);
        tx_en = 1'b1;
      end
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_idle(24 * FRAME + 3000);
    check("all words popped", 32'(rd_idx), 32'(sent_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte width read from the FIFO and serialized per frame.
REQ-002 Parameter CLKS_PER_BIT, default 10417, SHALL set the clock cycles per serial bit; legal range is 2 or more.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 tx_en  input  1  SHALL allow new frames to start while high.
REQ-006 fifo_empty  input  1  SHALL be the FIFO empty flag.
REQ-007 fifo_rdata  input  DATA_WIDTH  SHALL be the show-ahead FIFO head word, valid whenever fifo_empty is low.
REQ-008 fifo_rd  output  1  SHALL be the FIFO pop strobe, one cycle per consumed word.
REQ-009 tx  output  1  SHALL be the serial line, idle high.
REQ-010 busy  output  1  SHALL be high while any frame state other than IDLE is active.
REQ-011 tx_done  output  1  SHALL pulse high for one cycle when a frame's stop bit completes.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (only with PARITY_EN) and STOP.
REQ-013 IDLE SHALL transition to START on the edge where tx_en=1 and fifo_empty=0; the same edge latches fifo_rdata into the shift register and sets fifo_rd=1 for exactly the following cycle.
REQ-014 fifo_rd SHALL be registered, never high for two consecutive cycles, and never asserted while fifo_empty=1.
REQ-015 Every bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state entry and bit boundary.
REQ-016 In START, tx SHALL be 0 for one bit time.
REQ-017 In DATA, DATA_WIDTH bits SHALL be sent LSB first; a bit counter of ceil(log2(DATA_WIDTH)) bits SHALL wrap to 0 on leaving DATA.
REQ-018 In STOP, tx SHALL be 1 for one bit time.
REQ-019 When STOP ends with tx_en=1 and fifo_empty=0, the block SHALL go directly to START, pop as in REQ-013, and insert no idle cycle; otherwise it SHALL go to IDLE.
REQ-020 The tx_done pulse SHALL coincide with the first cycle after STOP ends, in either case of REQ-019.
REQ-021 A deassertion of tx_en mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-022 Changes on fifo_rdata or fifo_empty mid-frame SHALL NOT affect the frame in flight.
REQ-023 tx SHALL be driven from a register with no combinational path from inputs.

Reset
REQ-024 While reset=0, outputs SHALL immediately be tx=1, fifo_rd=0, busy=0 and tx_done=0, with the FSM in IDLE and all counters at 0.
REQ-025 Reset asserted mid-frame SHALL abandon the byte, which is lost and not re-popped, and the block SHALL resume from IDLE after release.

Configuration
REQ-026 With macro FIFO_UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA, sending the even-parity bit (XOR of the data bits) for one bit time, giving frame length (DATA_WIDTH+3)*CLKS_PER_BIT.
REQ-027 Without the macro, the PARITY state and its logic SHALL be absent, giving frame length (DATA_WIDTH+2)*CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, macro undefined unless stated)
REQ-028 Hold reset=0 with arbitrary inputs -> tx=1, fifo_rd=0, busy=0, tx_done=0.
REQ-029 Present a single word 0xA5 with tx_en=1 -> one fifo_rd pulse; tx gives 0 for 4 clk, then 1,0,1,0,0,1,0,1 for 4 clk each, then 1 for 4 clk; tx_done pulses once; 40-cycle frame.
REQ-030 Queue 0x00 then 0xFF -> two fifo_rd pulses exactly 40 cycles apart; the second start bit immediately follows the first stop bit.
REQ-031 Non-empty FIFO with tx_en=0 -> no fifo_rd and tx stays 1; drop tx_en during data bit 2 -> the frame completes and no further pop occurs.
REQ-032 Assert reset during data bit 3 -> tx=1 immediately; after release with the FIFO non-empty, the next word starts a full fresh frame.
REQ-033 With FIFO_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after the data bits; 44-cycle frame.
